// File: rtl/psum_binarizer.sv
// Accumulates signed PE-column partial sums over N passes, thresholds each total
// to one activation bit and packs 9 bits per output word behind a one-entry skid.
module psum_binarizer #(
  parameter int WIDTH     = 14,
  parameter int ACC_WIDTH = 18,
  parameter int PASS_BITS = 6
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 clear_in,
  input  logic [PASS_BITS-1:0] num_pass_in,
  input  logic [ACC_WIDTH-1:0] threshold_in,
  input  logic                 psum_valid_in,
  input  logic [WIDTH-1:0]     psum_in,
  output logic                 psum_ready_out,
  output logic [8:0]           word_out,
  output logic                 word_valid_out,
  input  logic                 word_ready_in,
  output logic                 overflow_out
);

  typedef enum logic [1:0] {IDLE, ACCUM, STALL} state_t;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t                 state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [PASS_BITS-1:0]   pass_cnt;
  logic [PASS_BITS-1:0]   num_pass_q;
  logic [3:0]             bit_cnt;
  logic [7:0]             pack;
  logic [8:0]             skid;

  logic                   accept;
  logic signed [ACC_WIDTH-1:0] psum_ext;
  logic signed [ACC_WIDTH:0]   sum_wide;
  logic                   sat_hi;
  logic                   sat_lo;
  logic                   sat_event;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic [PASS_BITS-1:0]   np_eff;
  logic                   last_pass;
  logic                   new_bit;
  logic [8:0]             new_word;

  assign psum_ready_out = (state != STALL);
  assign accept         = psum_valid_in && psum_ready_out && !clear_in;

  always_comb begin
    psum_ext  = {{(ACC_WIDTH-WIDTH){psum_in[WIDTH-1]}}, psum_in};
    sum_wide  = {acc[ACC_WIDTH-1], acc} + {psum_ext[ACC_WIDTH-1], psum_ext};
    sat_hi    = (sum_wide[ACC_WIDTH:ACC_WIDTH-1] == 2'b01);
    sat_lo    = (sum_wide[ACC_WIDTH:ACC_WIDTH-1] == 2'b10);
    sat_event = 1'b0;
    if (pass_cnt == '0) begin
      acc_next = psum_ext;
    end else if (sat_hi) begin
      acc_next  = ACC_MAX;
      sat_event = 1'b1;
    end else if (sat_lo) begin
      acc_next  = ACC_MIN;
      sat_event = 1'b1;
    end else begin
      acc_next = sum_wide[ACC_WIDTH-1:0];
    end
    // The pass count is latched at the first pass of a bit, so that pass must
    // already see the fresh configuration when deciding whether it is final.
    if (pass_cnt == '0)
      np_eff = (num_pass_in == '0) ? PASS_BITS'(1) : num_pass_in;
    else
      np_eff = num_pass_q;
    last_pass = (pass_cnt == np_eff - PASS_BITS'(1));
    new_bit   = (acc_next >= $signed(threshold_in));
    new_word  = {new_bit, pack};
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      acc            <= '0;
      pass_cnt       <= '0;
      num_pass_q     <= PASS_BITS'(1);
      bit_cnt        <= '0;
      pack           <= '0;
      skid           <= '0;
      word_out       <= '0;
      word_valid_out <= 1'b0;
      overflow_out   <= 1'b0;
    end else if (clear_in) begin
      state          <= IDLE;
      acc            <= '0;
      pass_cnt       <= '0;
      bit_cnt        <= '0;
      pack           <= '0;
      skid           <= '0;
      word_valid_out <= 1'b0;
      overflow_out   <= 1'b0;
    end else if (state == STALL) begin
      if (word_ready_in) begin
        word_out <= skid;
        state    <= (pass_cnt == '0 && bit_cnt == '0) ? IDLE : ACCUM;
      end
    end else begin
      if (word_valid_out && word_ready_in)
        word_valid_out <= 1'b0;
      if (accept) begin
        if (pass_cnt == '0)
          num_pass_q <= np_eff;
        if (sat_event)
          overflow_out <= 1'b1;
        if (last_pass) begin
          acc      <= '0;
          pass_cnt <= '0;
          if (bit_cnt == 4'd8) begin
            bit_cnt <= '0;
            pack    <= '0;
            // A pending word that is not being taken this edge pushes the new one into the skid.
            if (word_valid_out && !word_ready_in) begin
              skid  <= new_word;
              state <= STALL;
            end else begin
              word_out       <= new_word;
              word_valid_out <= 1'b1;
              state          <= IDLE;
            end
          end else begin
            pack[bit_cnt[2:0]] <= new_bit;
            bit_cnt            <= bit_cnt + 4'd1;
            state              <= ACCUM;
          end
        end else begin
          acc      <= acc_next;
          pass_cnt <= pass_cnt + PASS_BITS'(1);
          state    <= ACCUM;
        end
      end
    end
  end

endmodule

// File: doc/psum_binarizer.md
Name: psum_binarizer

Overview:
- Sits directly downstream of the bottom PE of each PE column and consumes that PE's signed partial-sum output.
- Accumulates partial sums over a programmable number of input-channel passes, then compares the total against a threshold to produce one binary activation.
- Packs 9 consecutive activations into a 9-bit word. This word has the same format as the 9-bit activation bus that feeds the next layer's PEs.
- Provides valid/ready flow control on the output and a ready signal back toward the array.

Parameters:
- WIDTH, 14, width of the signed partial sum from the PE column.
- ACC_WIDTH, 18, width of the signed accumulator and threshold.
- PASS_BITS, 6, width of the pass-count configuration.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- clear_in  input  1  synchronous flush of accumulator, counters and packer; takes priority over psum acceptance.
- num_pass_in  input  PASS_BITS  passes per output bit; sampled when pass count is 0; value 0 is treated as 1.
- threshold_in  input  ACC_WIDTH  signed threshold; sampled on the final pass of each bit.
- psum_valid_in  input  1  psum_in is valid this cycle.
- psum_in  input  WIDTH  signed partial sum from the PE column.
- psum_ready_out  output  1  block can accept psum_in this cycle.
- word_out  output  9  packed binary activations; bit k holds the k-th produced bit.
- word_valid_out  output  1  word_out is valid.
- word_ready_in  input  1  consumer accepts word_out.
- overflow_out  output  1  sticky flag: accumulator saturated; cleared by reset or clear_in.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - acc=0, pass_cnt=0, bit_cnt=0, pack=0, latched num_pass=1.
  - word_out=0, word_valid_out=0, overflow_out=0.
  - State=IDLE; psum_ready_out=1 on the first cycle after deassertion.
- Accept condition: psum_valid_in && psum_ready_out && !clear_in.
- psum_ready_out = !(state==STALL). It is combinational from state only, with no path from word_ready_in.
- State IDLE (pass_cnt==0, bit_cnt==0):
  - On accept: latch num_pass (0 treated as 1).
  - Go to ACCUM, or complete a bit immediately if num_pass==1.
- State ACCUM, on each accept:
  - When pass_cnt==0: acc_next = sext(psum_in). Otherwise: acc_next = sat(acc + sext(psum_in)).
  - Saturation clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] and sets overflow_out.
  - pass_cnt increments.
- Final pass (pass_cnt == num_pass-1 on accept):
  - bit = (acc_next >= threshold_in), signed compare.
  - pack[bit_cnt] <= bit; pass_cnt <= 0; acc <= 0; bit_cnt increments.
- Word completion (final pass with bit_cnt==8):
  - Next cycle: word_out = {bit, pack[7:0]} and word_valid_out=1; bit_cnt <= 0; pack <= 0.
  - Latency is 1 cycle from the accepting edge to word_valid_out.
- Output handshake:
  - word_out holds stable while word_valid_out && !word_ready_in.
  - word_valid_out falls on the edge where word_ready_in=1.
- State STALL:
  - Entered when a word completes while word_valid_out=1 and word_ready_in=0, i.e. the previous word is still pending.
  - The new word is held in a one-entry skid register; psum_ready_out=0.
  - On word_ready_in=1: the skid word moves to word_out (word_valid_out stays 1) and the state returns to ACCUM/IDLE.
  - No word is ever dropped or reordered.
- Back-to-back words with word_ready_in held 1 produce no stall.
- clear_in:
  - Next cycle: acc, pass_cnt, bit_cnt, pack, skid, overflow_out and word_valid_out are all 0; state=IDLE.
  - A psum presented in the same cycle is discarded.
- num_pass_in or threshold_in changing mid-bit: num_pass is unaffected until the next bit; threshold takes effect on the final pass only.
- Widths: psum_in is sign-extended to ACC_WIDTH before adding. The compare uses the full ACC_WIDTH signed.

Test Plan:
- Reset, then num_pass=1, threshold=0; feed psums +3,-1,0,+9,-9,+1,-3,+5,-7 with word_ready_in=1 -> word_out=9'b010101101 (bit k = psum_k>=0), word_valid_out high exactly one cycle after the 9th accept.
- num_pass=3, threshold=4; 27 psums in groups (2,1,1),(1,1,1),(5,-1,0)x7 -> bits 1,0,1..., word_out=9'b111111101; psum_ready_out stays 1 throughout.
- Backpressure: word_ready_in=0; complete two words -> first word held stable, second captured in skid, psum_ready_out=0; raise word_ready_in -> first word accepted, then second word presented next cycle, order preserved.
- Saturation: num_pass=40, psum_in=+8191 every pass -> acc clamps at 131071, overflow_out=1 and stays 1; threshold=131071 -> bit=1.
- clear_in asserted mid-bit (pass 2 of 3) and mid-word (bit 5) -> next cycle all state cleared, word_valid_out=0, overflow_out=0; the next 9 bits form a fresh word from bit 0.
- Async reset asserted while in STALL with word_valid_out=1 -> outputs drop to 0 immediately without a clock edge; psum_ready_out=1 after release.
